// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXE stage (master) and the
// multiply/divide unit (slave), including the MTHI/MTLO write port.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_divstep.sv
// One combinational restoring-division step on magnitudes: shifts the next
// dividend bit into the partial remainder and emits one quotient bit.
module muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           ge;

  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, divisor});

  // When ge holds the true difference is below the divisor, so the
  // modular WIDTH-bit subtraction is exact.
  assign rem_next = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-cycle multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   sh_hi_reg;
  logic [WIDTH-1:0]   sh_lo_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic               dz_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic               is_signed;
  logic               is_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);
  assign is_div    = (op_reg == OP_DIV)  || (op_reg == OP_DIVU);
  assign abs_a     = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign abs_b     = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // Shift-add multiply: sh_lo holds the unconsumed multiplier bits.
  assign mul_sum = {1'b0, sh_hi_reg} + (sh_lo_reg[0] ? {1'b0, opnd_reg} : '0);

  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (sh_hi_reg),
    .quo      (sh_lo_reg),
    .divisor  (opnd_reg),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  assign prod = {sh_hi_reg, sh_lo_reg};

  always_comb begin
    fix_hi = sh_hi_reg;
    fix_lo = sh_lo_reg;
    if (!is_div) begin
      if (neg_lo_reg) {fix_hi, fix_lo} = -prod;
    end else if (dz_reg) begin
      // sh_lo still holds |a| here, so re-applying the dividend sign yields a.
      fix_lo = '1;
      fix_hi = neg_hi_reg ? -sh_lo_reg : sh_lo_reg;
    end else begin
      fix_lo = neg_lo_reg ? -sh_lo_reg : sh_lo_reg;
      fix_hi = neg_hi_reg ? -sh_hi_reg : sh_hi_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      opnd_reg   <= '0;
      sh_hi_reg  <= '0;
      sh_lo_reg  <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (bus.start) begin
          if (!bus.cancel) begin
            op_reg    <= bus.op;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            state_reg <= ST_PREP;
          end
        end else begin
          if (bus.wr_hi) hi_reg <= bus.wdata;
          if (bus.wr_lo) lo_reg <= bus.wdata;
        end
      end else if (bus.cancel) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_PREP: begin
            cnt_reg    <= '0;
            sh_hi_reg  <= '0;
            neg_lo_reg <= is_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
            neg_hi_reg <= is_signed && a_reg[WIDTH-1];
            dz_reg     <= is_div && (b_reg == '0);
            state_reg  <= ST_ITER;
            if (is_div) begin
              opnd_reg  <= abs_b;
              sh_lo_reg <= abs_a;
            end else begin
              opnd_reg  <= abs_a;
              sh_lo_reg <= abs_b;
`ifdef MULDIV_FAST_MUL_EN
              {sh_hi_reg, sh_lo_reg} <= fast_prod;
              state_reg              <= ST_FIX;
`endif
            end
          end
          ST_ITER: begin
            // A zero divisor is caught on the latched operand in the first
            // iteration slot, leaving the dividend magnitude untouched.
            if (dz_reg) begin
              state_reg <= ST_FIX;
            end else begin
              if (is_div) begin
                sh_hi_reg <= div_rem;
                sh_lo_reg <= div_quo;
              end else begin
                {sh_hi_reg, sh_lo_reg} <= {mul_sum, sh_lo_reg[WIDTH-1:1]};
              end
              cnt_reg <= cnt_reg + 1'b1;
              if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= ST_FIX;
            end
          end
          ST_FIX: begin
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state_reg != ST_IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MUL_EN for multiply timing).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC   = 3;
  localparam int MUL_MID   = 2;
  localparam int MUL_CANCL = 2;
`else
  localparam int MUL_CYC   = W + 3;
  localparam int MUL_MID   = 5;
  localparam int MUL_CANCL = 10;
`endif
  localparam int DIV_CYC = W + 3;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  // Leaves the bench in cycle 1 of the new op.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  // Advances from cycle cyc until done, tracking busy and HI/LO hold.
  task automatic wait_done(input int limit, inout int cyc, output bit hold_ok);
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < limit) begin
      if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic finish_op(input string tag, input int cyc, input int exp_cyc,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    bit hold_ok;
    int c;
    c = cyc;
    wait_done(exp_cyc + 8, c, hold_ok);
    check({tag, ".cycle"}, 64'(c), 64'(exp_cyc));
    check({tag, ".hold"}, 64'(hold_ok), 64'd1);
    check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, ".busy0"}, 64'(bus.busy), 64'd0);
    step();
    check({tag, ".pulse"}, 64'(bus.done), 64'd0);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_cyc,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    launch(op, a, b);
    finish_op(tag, 1, exp_cyc, exp_hi, exp_lo);
  endtask

  initial begin
    int  c;
    bit  quiet;
    n_assert = 0;
    n_fail   = 0;
    m_hi     = '0;
    m_lo     = '0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    bus.wr_hi  = 1'b0;
    bus.wr_lo  = 1'b0;
    bus.wdata  = '0;

    repeat (3) step();
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    rst = 1'b1;
    step();

    // MTHI in idle, no done pulse
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h0000_1234;
    step();
    bus.wr_hi = 1'b0;
    check("mthi.hi", 64'(bus.hi), 64'h1234);
    check("mthi.done", 64'(bus.done), 64'd0);
    m_hi = 32'h0000_1234;

    run_op("divu14_2", OP_DIVU, 32'd14, 32'd2, DIV_CYC, 32'd0, 32'd7);
    run_op("mult-3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, MUL_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_CYC, 32'd1, 32'hFFFF_FFFE);
    run_op("mult-1x-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC, 32'd0, 32'd1);
    run_op("div-7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div7_-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_CYC, 32'd1, 32'hFFFF_FFFD);
    run_op("div_min_-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYC, 32'd0, 32'h8000_0000);
    run_op("divu9_0", OP_DIVU, 32'd9, 32'd0, 4, 32'd9, 32'hFFFF_FFFF);
    run_op("div-9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 4, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Preset both halves, then abort a multiply
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_00A5;
    step();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    check("preset.hi", 64'(bus.hi), 64'hA5);
    check("preset.lo", 64'(bus.lo), 64'hA5);
    m_hi = 32'hA5;
    m_lo = 32'hA5;

    launch(OP_MULT, 32'd6, 32'd7);
    repeat (MUL_CANCL - 1) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel.busy", 64'(bus.busy), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      if (bus.done !== 1'b0) quiet = 1'b0;
      step();
    end
    check("cancel.nodone", 64'(quiet), 64'd1);
    check("cancel.hi", 64'(bus.hi), 64'hA5);
    check("cancel.lo", 64'(bus.lo), 64'hA5);

    // Cancel landing on the FIX cycle of a divide suppresses the commit
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (DIV_CYC - 2) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cfix.done", 64'(bus.done), 64'd0);
    check("cfix.busy", 64'(bus.busy), 64'd0);
    check("cfix.lo", 64'(bus.lo), 64'hA5);

    // Cancel with start in idle drops the start
    bus.cancel = 1'b1;
    launch(OP_MULT, 32'd6, 32'd7);
    bus.cancel = 1'b0;
    check("cstart.busy", 64'(bus.busy), 64'd0);

    // A start while busy is ignored
    launch(OP_MULT, 32'd6, 32'd7);
    repeat (MUL_MID - 1) step();
    launch(OP_MULTU, 32'd9, 32'd9);
    finish_op("ignore2nd", MUL_MID + 1, MUL_CYC, 32'd0, 32'd42);
    step();
    check("ignore2nd.idle", 64'(bus.busy), 64'd0);

    // Start together with MTHI: op wins, write dropped
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    launch(OP_MULTU, 32'd3, 32'd4);
    bus.wr_hi = 1'b0;
    check("startwr.hi", 64'(bus.hi), 64'd0);
    finish_op("startwr", 1, MUL_CYC, 32'd0, 32'd12);

    // MTLO while busy is dropped
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (2) step();
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_0055;
    step();
    bus.wr_lo = 1'b0;
    check("busywr.lo", 64'(bus.lo), 64'(m_lo));
    finish_op("divu100_7", 4, DIV_CYC, 32'd2, 32'd14);

    // Asynchronous reset in the middle of an op
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (11) step();
    rst = 1'b0;
    #1;
    check("arst.busy", 64'(bus.busy), 64'd0);
    check("arst.done", 64'(bus.done), 64'd0);
    check("arst.hi", 64'(bus.hi), 64'd0);
    check("arst.lo", 64'(bus.lo), 64'd0);
    step();
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    step();

    run_op("mult6x7", OP_MULT, 32'd6, 32'd7, MUL_CYC, 32'd0, 32'd42);

    c = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
